// File: rtl/buffer_pkg.sv
// buffer_pkg: shared widths for the 512<->64 gearbox buffers
package buffer_pkg;
  localparam int IN_W   = 512;
  localparam int OUT_W  = 64;
  localparam int LANES  = IN_W / OUT_W;
  localparam int LANE_W = $clog2(LANES);
endpackage

// File: rtl/buffer_512_to_64_if.sv
// buffer_512_to_64_if: load/drain bus of the 512->64 gearbox
//   clr, data_in, wr_enable, rd_enable : driven by the user side (master)
//   data_out, full, full_n, empty, rd_last : driven by the buffer (slave)
interface buffer_512_to_64_if;
  import buffer_pkg::*;
  logic              clr;
  logic [IN_W-1:0]   data_in;
  logic              wr_enable;
  logic              rd_enable;
  logic [OUT_W-1:0]  data_out;
  logic              full;
  logic              full_n;
  logic              empty;
  logic              rd_last;
  modport master (output clr, data_in, wr_enable, rd_enable,
                  input  data_out, full, full_n, empty, rd_last);
  modport slave  (input  clr, data_in, wr_enable, rd_enable,
                  output data_out, full, full_n, empty, rd_last);
endinterface

// File: rtl/buffer_512_to_64.sv
// buffer_512_to_64: SLOTS-deep 512-bit store drained as eight 64-bit lanes, lane 0 first
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset, clears all state including storage
//   bus  : slave side of buffer_512_to_64_if (load, drain, flags)
module buffer_512_to_64
  import buffer_pkg::*;
#(
  parameter int SLOTS = 2
) (
  input logic               clk,
  input logic               rst,
  buffer_512_to_64_if.slave bus
);
  localparam int PTR_W = SLOTS > 1 ? $clog2(SLOTS) : 1;
  localparam int CNT_W = $clog2(SLOTS + 1);
  logic [IN_W-1:0]   mem [SLOTS];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LANE_W-1:0] lane;
  logic [CNT_W-1:0]  count;
  logic              wr_ok, rd_ok, pop;
  // pointers wrap modulo SLOTS, which need not fill PTR_W bits when SLOTS == 1
  function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SLOTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction
  assign bus.empty    = (count == '0);
  assign bus.full     = (count == CNT_W'(SLOTS));
  assign bus.full_n   = ~bus.full;
  assign bus.rd_last  = (lane == LANE_W'(LANES - 1)) && !bus.empty;
  assign bus.data_out = mem[rd_ptr][lane*OUT_W +: OUT_W];
  // full is the registered flag, so a lane-7 read cannot free room for a same-cycle write
  assign wr_ok = bus.wr_enable && !bus.full;
  assign rd_ok = bus.rd_enable && !bus.empty;
  assign pop   = rd_ok && (lane == LANE_W'(LANES - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      lane   <= '0;
      count  <= '0;
    end else if (bus.clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lane   <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr      <= adv(wr_ptr);
      end
      if (rd_ok) lane <= lane + LANE_W'(1);
      if (pop) rd_ptr <= adv(rd_ptr);
      count <= count + CNT_W'(wr_ok) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_buffer_512_to_64.sv
// tb_buffer_512_to_64: directed self-checking bench for buffer_512_to_64 (SLOTS=2)
module tb_buffer_512_to_64;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int failures = 0;
  buffer_512_to_64_if bus ();
  buffer_512_to_64 #(.SLOTS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [511:0] mkw(input logic [7:0] base);
    logic [511:0] w;
    for (int k = 0; k < 8; k++) w[64*k +: 64] = 64'(base) + 64'(k);
    return w;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic write_word(input logic [7:0] base);
    bus.data_in = mkw(base);
    bus.wr_enable = 1;
    tick();
    bus.wr_enable = 0;
  endtask
  task automatic read_lanes(input logic [7:0] base, input int n);
    bus.rd_enable = 1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.data_out !== 64'(base) + 64'(i)) begin
        failures++;
        $display("FAIL read_lane %0d: got %h want %h", i, bus.data_out, 64'(base) + 64'(i));
      end
      checks++;
      if (bus.rd_last !== (i == 7)) begin
        failures++;
        $display("FAIL rd_last lane %0d: got %b want %b", i, bus.rd_last, i == 7);
      end
      tick();
    end
    bus.rd_enable = 0;
  endtask
  task automatic chk_flags(input string nm, input logic e, input logic f);
    checks++;
    if (bus.empty !== e || bus.full !== f || bus.full_n !== !f) begin
      failures++;
      $display("FAIL %s: got empty=%b full=%b full_n=%b want empty=%b full=%b full_n=%b",
               nm, bus.empty, bus.full, bus.full_n, e, f, !f);
    end
  endtask
  task automatic test_reset();
    bus.clr = 0;
    bus.data_in = '0;
    bus.wr_enable = 0;
    bus.rd_enable = 0;
    #12 rst = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_flags("reset_idle", 1, 0);
      checks++;
      if (bus.data_out !== 64'h0 || bus.rd_last !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_out: got data_out=%h rd_last=%b want 0 0", bus.data_out, bus.rd_last);
      end
    end
  endtask
  task automatic test_single();
    write_word(8'h10);
    chk_flags("single_after_write", 0, 0);
    read_lanes(8'h10, 8);
    chk_flags("single_drained", 1, 0);
  endtask
  task automatic test_full();
    write_word(8'h10);
    chk_flags("full_after_w1", 0, 0);
    write_word(8'h20);
    chk_flags("full_after_w2", 0, 1);
    write_word(8'h30);
    chk_flags("full_after_w3", 0, 1);
    read_lanes(8'h10, 8);
    read_lanes(8'h20, 8);
    chk_flags("full_drained", 1, 0);
  endtask
  task automatic test_full_lane7();
    write_word(8'h40);
    write_word(8'h50);
    read_lanes(8'h40, 7);
    checks++;
    if (bus.rd_last !== 1'b1 || bus.data_out !== 64'h47) begin
      failures++;
      $display("FAIL fl7_at_lane7: got rd_last=%b data_out=%h want 1 47", bus.rd_last, bus.data_out);
    end
    chk_flags("fl7_full_before", 0, 1);
    bus.data_in = mkw(8'h60);
    bus.wr_enable = 1;
    bus.rd_enable = 1;
    tick();
    bus.wr_enable = 0;
    bus.rd_enable = 0;
    chk_flags("fl7_write_rejected", 0, 0);
    write_word(8'h60);
    chk_flags("fl7_rewrite", 0, 1);
    read_lanes(8'h50, 8);
    read_lanes(8'h60, 8);
    chk_flags("fl7_drained", 1, 0);
  endtask
  task automatic test_back_to_back();
    write_word(8'h70);
    read_lanes(8'h70, 7);
    bus.data_in = mkw(8'h80);
    bus.wr_enable = 1;
    bus.rd_enable = 1;
    tick();
    bus.wr_enable = 0;
    chk_flags("b2b_count_kept", 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.empty !== 1'b0 || bus.data_out !== 64'h80 + 64'(i)) begin
        failures++;
        $display("FAIL b2b_lane %0d: got empty=%b data_out=%h want 0 %h",
                 i, bus.empty, bus.data_out, 64'h80 + 64'(i));
      end
      tick();
    end
    bus.rd_enable = 0;
    chk_flags("b2b_drained", 1, 0);
  endtask
  task automatic test_clr();
    write_word(8'h90);
    read_lanes(8'h90, 3);
    bus.clr = 1;
    tick();
    bus.clr = 0;
    chk_flags("clr_empty", 1, 0);
    checks++;
    if (bus.rd_last !== 1'b0) begin
      failures++;
      $display("FAIL clr_rd_last: got %b want 0", bus.rd_last);
    end
    write_word(8'ha0);
    read_lanes(8'ha0, 8);
    chk_flags("clr_drained", 1, 0);
  endtask
  task automatic test_rst_mid();
    write_word(8'hb0);
    read_lanes(8'hb0, 3);
    rst = 0;
    #1;
    chk_flags("rst_async_flags", 1, 0);
    checks++;
    if (bus.data_out !== 64'h0 || bus.rd_last !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_out: got data_out=%h rd_last=%b want 0 0", bus.data_out, bus.rd_last);
    end
    #2 rst = 1;
    tick();
    chk_flags("rst_after_release", 1, 0);
    write_word(8'hc0);
    read_lanes(8'hc0, 8);
    chk_flags("rst_drained", 1, 0);
  endtask
  initial begin
    test_reset();
    test_single();
    test_full();
    test_full_lane7();
    test_back_to_back();
    test_clr();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/buffer_512_to_64.md
# buffer_512_to_64

Width-down gearbox: accepts whole 512-bit words and emits them as eight consecutive 64-bit words, least-significant lane first. It is the transmit-side counterpart of the 64→512 packing buffer. It sits between the 512-bit memory/accelerator datapath and the 64-bit register/stream side. It holds up to SLOTS full 512-bit words, so a new word can be loaded while the previous one drains.

## Interface
- SLOTS, 2, number of 512-bit storage slots (≥1, power of two)
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear; returns pointers/counters to reset state
- data_in  in  512  word to load
- wr_enable  in  1  load data_in this cycle
- data_out  out  64  current lane of head slot
- rd_enable  in  1  consume data_out this cycle
- full  out  1  all SLOTS occupied
- full_n  out  1  ~full
- empty  out  1  no lane available
- rd_last  out  1  data_out is lane 7 of the head slot (valid when !empty)

## Operation
- State: slot storage [SLOTS][512], wr_ptr and rd_ptr (log2 SLOTS bits, wrap modulo SLOTS), lane counter 0..7, occupancy count 0..SLOTS.
- Write accepted iff wr_enable && !full, with full sampled at the start of the cycle. The word is stored at wr_ptr; wr_ptr advances and count increments. A write while full is ignored and causes no state change.
- data_out = head slot bits [64*lane+63 : 64*lane], selected combinationally from rd_ptr and lane.
- Read accepted iff rd_enable && !empty. On acceptance the lane increments.
- On the lane-7 read: lane wraps to 0, rd_ptr advances, count decrements.
- A read while empty is ignored.
- Simultaneous accepted write and lane-7 read: count is unchanged and both pointers advance. If the buffer was full, the write is still rejected, because full was sampled before the read.
- empty = (count == 0); full = (count == SLOTS); rd_last = (lane == 7) && !empty.
- clr has priority over wr_enable and rd_enable. It zeroes the pointers, lane and count; storage contents are retained.
- rst has priority over everything. It zeroes all state, including storage.

## Timing
- Reset values: data_out=0, full=0, full_n=1, empty=1, rd_last=0.
- Write latency: a write accepted at edge N gives empty=0 and a valid data_out from edge N to N+1.
- Flags are registered-derived and change only on clock edges; there is no combinational path from wr_enable or rd_enable to the flags.
- Sustained throughput is one 512-bit word per 8 cycles with rd_enable held high, given SLOTS ≥ 2 and a writer refilling on lane 7.
- Reset asserted mid-drain: outputs go to reset values immediately (asynchronous); the partial word is discarded.
- data_out is don't-care while empty (after clr it may show stale storage).

## Structure
- Package buffer_pkg holds:
  - IN_W=512, OUT_W=64, LANES=IN_W/OUT_W=8, LANE_W=$clog2(LANES);
  - shared with the 64→512 buffer.
- Single module with no sub-module; the lane select is an indexed part-select.

## Test plan
- Reset, then idle: empty=1, full=0, full_n=1, data_out=0, rd_last=0 for 10 cycles.
- Write one word whose lane k = 64'h10+k, then hold rd_enable for 8 cycles:
  - data_out goes 64'h10..64'h17 on consecutive cycles;
  - rd_last=1 only on 64'h17;
  - empty=1 after the 8th read.
- With SLOTS=2, write three words (lanes 0x1k, 0x2k, 0x3k):
  - full=1 and full_n=0 after the 2nd write;
  - the 3rd write is ignored;
  - draining 16 lanes yields 0x10..0x17 then 0x20..0x27, then empty.
- Buffer full and on lane 7, with wr_enable and rd_enable both asserted:
  - the read is accepted and the write is rejected;
  - full deasserts next cycle;
  - re-issuing the write then succeeds.
- Single slot at lane 7 with one free slot, simultaneous write and read:
  - count stays 1;
  - the next data_out is lane 0 of the new word;
  - empty never asserts.
- Mid-drain, after 3 reads, cover two cases:
  - clr pulse: empty=1 next cycle; subsequent write and 8 reads return the new word intact;
  - rst asserted between edges: flags go to reset values before the next edge.
